// File: rtl/mag_cmp_seq_if.sv
// Handshake and operand/result bundle for the sequential magnitude comparator.
// The master side issues compares; the slave side is the comparator itself.
interface mag_cmp_seq_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
);
  localparam int SW = $clog2(WIDTH / STEP + 1);

  logic             start;
  logic             en;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [SW-1:0]    slices;

  modport master (
    output start, en, is_signed, a, b,
    input  busy, done, lt, eq, gt, slices
  );

  modport slave (
    input  start, en, is_signed, a, b,
    output busy, done, lt, eq, gt, slices
  );
endinterface

// File: rtl/mag_cmp_seq.sv
// Sequential MSB-first magnitude comparator: STEP bits per clock, optional
// early exit on the first differing slice, unsigned or two's-complement operands.
module mag_cmp_seq #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mag_cmp_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / STEP;
  localparam int CW     = $clog2(NSLICE + 1);

  generate
    if (WIDTH < 2 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("mag_cmp_seq: WIDTH must be >= 2 and a multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             en_q;
  logic [CW-1:0]    cnt;
  logic             diff_found, diff_gt;
  logic             lt_q, eq_q, gt_q;
  logic [CW-1:0]    slices_q;

  logic [STEP-1:0]  a_sl, b_sl;
  logic             slice_ne, rec_diff, rec_gt, last, finish, capture;

  // Operands are shifted left each RUN cycle, so the active slice is always the top one.
  assign a_sl     = a_q[WIDTH-1 -: STEP];
  assign b_sl     = b_q[WIDTH-1 -: STEP];
  assign slice_ne = (a_sl != b_sl);
  assign rec_diff = diff_found | slice_ne;
  assign rec_gt   = diff_found ? diff_gt : (a_sl > b_sl);
  assign last     = (cnt == CW'(NSLICE - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        capture   = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last || (EARLY_EXIT && slice_ne)) begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: captured operands and result flags are ordinary flops, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      en_q       <= 1'b0;
      cnt        <= '0;
      diff_found <= 1'b0;
      diff_gt    <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
      slices_q   <= '0;
    end else if (capture) begin
      // Flipping the MSB maps two's-complement onto offset-binary ordering.
      a_q        <= {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
      b_q        <= {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
      en_q       <= bus.en;
      cnt        <= '0;
      diff_found <= 1'b0;
      diff_gt    <= 1'b0;
    end else if (state == RUN) begin
      a_q        <= a_q << STEP;
      b_q        <= b_q << STEP;
      cnt        <= cnt + CW'(1);
      diff_found <= rec_diff;
      diff_gt    <= rec_gt;
      if (finish) begin
        lt_q     <= en_q & rec_diff & ~rec_gt;
        gt_q     <= en_q & rec_diff & rec_gt;
        eq_q     <= en_q & ~rec_diff;
        slices_q <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.lt     = lt_q;
  assign bus.eq     = eq_q;
  assign bus.gt     = gt_q;
  assign bus.slices = slices_q;
endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed bench for mag_cmp_seq: three instances cover STEP=2 early-exit,
// STEP=1 fixed latency and STEP=1 early-exit, all at WIDTH=8.
module tb_mag_cmp_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mag_cmp_seq_if #(.WIDTH(8), .STEP(2)) if0 ();
  mag_cmp_seq_if #(.WIDTH(8), .STEP(1)) if1 ();
  mag_cmp_seq_if #(.WIDTH(8), .STEP(1)) if2 ();

  mag_cmp_seq #(.WIDTH(8), .STEP(2), .EARLY_EXIT(1'b1)) u_s2_ee (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mag_cmp_seq #(.WIDTH(8), .STEP(1), .EARLY_EXIT(1'b0)) u_s1_fx (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mag_cmp_seq #(.WIDTH(8), .STEP(1), .EARLY_EXIT(1'b1)) u_s1_ee (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic en, input logic sg,
                       input logic [7:0] a, input logic [7:0] b);
    case (d)
      0: begin if0.start = st; if0.en = en; if0.is_signed = sg; if0.a = a; if0.b = b; end
      1: begin if1.start = st; if1.en = en; if1.is_signed = sg; if1.a = a; if1.b = b; end
      default: begin if2.start = st; if2.en = en; if2.is_signed = sg; if2.a = a; if2.b = b; end
    endcase
  endtask

  // flags packed as {lt, eq, gt}
  task automatic sample(input int d, output logic bsy, output logic dn,
                        output logic [2:0] f, output logic [3:0] sl);
    case (d)
      0: begin bsy = if0.busy; dn = if0.done; f = {if0.lt, if0.eq, if0.gt}; sl = {1'b0, if0.slices}; end
      1: begin bsy = if1.busy; dn = if1.done; f = {if1.lt, if1.eq, if1.gt}; sl = if1.slices; end
      default: begin bsy = if2.busy; dn = if2.done; f = {if2.lt, if2.eq, if2.gt}; sl = if2.slices; end
    endcase
  endtask

  // One full transaction: measure busy length, then check the done cycle and result.
  task automatic do_cmp(input int d, input logic en, input logic sg,
                        input logic [7:0] a, input logic [7:0] b,
                        input int exp_n, input logic [2:0] exp_f, input int exp_sl,
                        input string tag);
    logic bsy, dn;
    logic [2:0] f;
    logic [3:0] sl;
    int n;
    @(negedge clk);
    drive(d, 1'b1, en, sg, a, b);
    @(posedge clk);
    #1 drive(d, 1'b0, en, sg, a, b);
    n = 0;
    @(negedge clk);
    sample(d, bsy, dn, f, sl);
    while (bsy && n < 40) begin
      n++;
      @(negedge clk);
      sample(d, bsy, dn, f, sl);
    end
    check({tag, "_busy_cycles"}, n, exp_n);
    check({tag, "_done"}, 32'(dn), 32'd1);
    check({tag, "_flags"}, 32'(f), 32'(exp_f));
    check({tag, "_slices"}, 32'(sl), exp_sl);
    @(negedge clk);
    sample(d, bsy, dn, f, sl);
    check({tag, "_done_pulse_end"}, 32'(dn), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic bsy, dn;
    logic [2:0] f, f_done;
    logic [3:0] sl, sl_done;
    int busy_n, done_n;

    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    for (int d = 0; d < 3; d++) begin
      sample(d, bsy, dn, f, sl);
      check($sformatf("reset_busy_%0d", d), 32'(bsy), 32'd0);
      check($sformatf("reset_done_%0d", d), 32'(dn), 32'd0);
      check($sformatf("reset_flags_%0d", d), 32'(f), 32'd0);
      check($sformatf("reset_slices_%0d", d), 32'(sl), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // STEP=2: equal operands run all four slices
    do_cmp(0, 1'b1, 1'b0, 8'h5A, 8'h5A, 4, 3'b010, 4, "s2_eq");
    // top slice 10 vs 01
    do_cmp(0, 1'b1, 1'b0, 8'h80, 8'h7F, 1, 3'b001, 1, "s2_unsigned_gt");
    // -128 vs 127
    do_cmp(0, 1'b1, 1'b1, 8'h80, 8'h7F, 1, 3'b100, 1, "s2_signed_lt");
    // STEP=1 first difference at bit 1, i.e. the seventh slice
    do_cmp(1, 1'b1, 1'b0, 8'h01, 8'h03, 8, 3'b100, 8, "s1_fixed_lt");
    do_cmp(2, 1'b1, 1'b0, 8'h01, 8'h03, 7, 3'b100, 7, "s1_early_lt");
    // bit 7 says gt, every later bit says lt: the first difference must stick
    do_cmp(1, 1'b1, 1'b0, 8'h80, 8'h7F, 8, 3'b001, 8, "s1_fixed_first_wins");
    do_cmp(1, 1'b1, 1'b1, 8'hC3, 8'hC3, 8, 3'b010, 8, "s1_fixed_signed_eq");
    // -1 vs +1
    do_cmp(2, 1'b1, 1'b1, 8'hFF, 8'h01, 1, 3'b100, 1, "s1_early_signed_lt");
    // en=0: 0x10 vs 0x20 first differs in slice [5:4], the second slice
    do_cmp(0, 1'b0, 1'b0, 8'h10, 8'h20, 2, 3'b000, 2, "s2_en0_ne");
    do_cmp(0, 1'b0, 1'b0, 8'h33, 8'h33, 4, 3'b000, 4, "s2_en0_eq");
    do_cmp(0, 1'b1, 1'b0, 8'h3C, 8'h3D, 4, 3'b100, 4, "s2_last_slice_lt");

    // start while busy is ignored; flags from the previous compare (lt) are held meanwhile
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h12);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h12);
    @(negedge clk);
    sample(0, bsy, dn, f, sl);
    check("hold_flags_during_run", 32'(f), 32'(3'b100));
    busy_n = bsy ? 1 : 0;
    done_n = 0;
    f_done = '0;
    sl_done = '0;
    drive(0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
      sample(0, bsy, dn, f, sl);
      busy_n += bsy ? 1 : 0;
      if (dn) begin
        done_n++;
        f_done = f;
        sl_done = sl;
      end
    end
    check("busy_start_busy_cycles", busy_n, 4);
    check("busy_start_done_count", done_n, 1);
    check("busy_start_flags", 32'(f_done), 32'(3'b010));
    check("busy_start_slices", 32'(sl_done), 32'd4);

    // start in the DONE cycle is ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 8'hC0, 8'h40);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 1'b0, 8'hC0, 8'h40);
    @(negedge clk);
    @(negedge clk);
    sample(0, bsy, dn, f, sl);
    check("done_cycle_done", 32'(dn), 32'd1);
    check("done_cycle_flags", 32'(f), 32'(3'b001));
    drive(0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    @(negedge clk);
    sample(0, bsy, dn, f, sl);
    check("done_cycle_start_ignored_busy", 32'(bsy), 32'd0);
    check("done_cycle_start_ignored_done", 32'(dn), 32'd0);
    @(negedge clk);
    sample(0, bsy, dn, f, sl);
    check("done_cycle_start_ignored_busy2", 32'(bsy), 32'd0);
    check("done_cycle_flags_held", 32'(f), 32'(3'b001));

    // reset mid-RUN after an eq result is loaded
    do_cmp(0, 1'b1, 1'b0, 8'h77, 8'h77, 4, 3'b010, 4, "pre_reset_eq");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 sample(0, bsy, dn, f, sl);
    check("async_reset_busy", 32'(bsy), 32'd0);
    check("async_reset_done", 32'(dn), 32'd0);
    check("async_reset_flags", 32'(f), 32'd0);
    check("async_reset_slices", 32'(sl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample(0, bsy, dn, f, sl);
      busy_n += bsy ? 1 : 0;
      done_n += dn ? 1 : 0;
    end
    check("post_reset_no_busy", busy_n, 0);
    check("post_reset_no_done", done_n, 0);
    do_cmp(0, 1'b1, 1'b0, 8'hC0, 8'h40, 1, 3'b001, 1, "post_reset_gt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
